// File: rtl/seg7_scan_display.sv
// seg7_scan_display
//   Multiplexed 7-segment scan driver. Scans NDIGITS hex nibbles onto a shared
//   segment bus, one digit slot every SCAN_DIV clocks. The displayed word, decimal
//   points and blanking are latched once per frame so a digit sweep never tears.
//   An accepted event word replaces live data for HOLD_FRAMES full frames.
// Ports
//   clk_i, reset_n_i         clock, async active-low reset
//   data_in_i [4*NDIGITS]    live word, nibble i -> digit i (digit 0 rightmost)
//   dp_in_i, blank_in_i      per-digit decimal point / force-dark requests
//   lz_suppress_i            blank leading zero digits (digit 0 always shown)
//   evt_valid_i/evt_data_i   event offer; evt_ready_o high only in IDLE
//   an_o, seg_o, dp_o        digit enables, segments {g..a}, decimal point
//   frame_done_o             1-cycle pulse when the scan wraps to digit 0
//   holding_o                event word is the displayed source
module seg7_scan_display #(
  parameter int NDIGITS     = 8,
  parameter int SCAN_DIV    = 263158,
  parameter int HOLD_FRAMES = 64,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [4*NDIGITS-1:0]   data_in_i,
  input  logic [NDIGITS-1:0]     dp_in_i,
  input  logic [NDIGITS-1:0]     blank_in_i,
  input  logic                   lz_suppress_i,
  input  logic                   evt_valid_i,
  input  logic [4*NDIGITS-1:0]   evt_data_i,
  output logic                   evt_ready_o,
  output logic [NDIGITS-1:0]     an_o,
  output logic [6:0]             seg_o,
  output logic                   dp_o,
  output logic                   frame_done_o,
  output logic                   holding_o
);
  localparam int W  = 4*NDIGITS;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int CW = $clog2(HOLD_FRAMES+1);
  localparam logic [PW-1:0] PMAX      = PW'(SCAN_DIV-1);
  localparam logic [IW-1:0] ILAST     = IW'(NDIGITS-1);
  localparam logic [CW-1:0] HOLD_INIT = CW'(HOLD_FRAMES);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

  // Active-low segment patterns {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex2seg(input logic [3:0] n);
    case (n)
      4'h0: hex2seg = 7'h40;  4'h1: hex2seg = 7'h79;
      4'h2: hex2seg = 7'h24;  4'h3: hex2seg = 7'h30;
      4'h4: hex2seg = 7'h19;  4'h5: hex2seg = 7'h12;
      4'h6: hex2seg = 7'h02;  4'h7: hex2seg = 7'h78;
      4'h8: hex2seg = 7'h00;  4'h9: hex2seg = 7'h10;
      4'hA: hex2seg = 7'h08;  4'hB: hex2seg = 7'h03;
      4'hC: hex2seg = 7'h46;  4'hD: hex2seg = 7'h21;
      4'hE: hex2seg = 7'h06;  4'hF: hex2seg = 7'h0E;
      default: hex2seg = 7'h7F;
    endcase
  endfunction

  logic [PW-1:0]      presc_q, presc_d;
  logic [IW-1:0]      idx_q, idx_d;
  state_e             state_q, state_d;
  logic [CW-1:0]      hold_cnt_q, hold_cnt_d;
  logic [W-1:0]       evt_buf_q, evt_buf_d;
  logic [W-1:0]       snap_word_q, snap_word_d;
  logic [NDIGITS-1:0] snap_dp_q, snap_dp_d, snap_blank_q, snap_blank_d;
  logic               holding_q, holding_d;
  logic [NDIGITS-1:0] an_q, an_d;      // held in active-low sense internally
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d, fd_q, fd_d;

  logic               tick, boundary, use_evt;
  logic [NDIGITS:0]   lz_run;          // lz_run[i]: nibbles i..top all zero
  logic [3:0]         nib;
  logic               dark, dp_sel;
  logic [NDIGITS-1:0] an_sel;

  assign tick     = (presc_q == PMAX);
  assign boundary = tick && (idx_q == ILAST);
  assign use_evt  = (state_q == HOLD) && (hold_cnt_q != '0);

  // FSM: state register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      evt_buf_q  <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      evt_buf_q  <= evt_buf_d;
    end
  end

  // FSM: next state. An accept on a boundary edge leaves that boundary on live
  // data because use_evt still sees IDLE.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    evt_buf_d  = evt_buf_q;
    case (state_q)
      IDLE: if (evt_valid_i) begin
        state_d    = HOLD;
        hold_cnt_d = HOLD_INIT;
        evt_buf_d  = evt_data_i;
      end
      HOLD: if (boundary) begin
        if (hold_cnt_q != '0) hold_cnt_d = hold_cnt_q - 1'b1;
        else                  state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    evt_ready_o = (state_q == IDLE);
  end

  // Scan datapath next state
  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (tick) idx_d = (idx_q == ILAST) ? '0 : idx_q + 1'b1;

    snap_word_d  = snap_word_q;
    snap_dp_d    = snap_dp_q;
    snap_blank_d = snap_blank_q;
    holding_d    = holding_q;
    if (boundary) begin
      snap_word_d  = use_evt ? evt_buf_q : data_in_i;
      snap_dp_d    = dp_in_i;
      snap_blank_d = blank_in_i;
      holding_d    = use_evt;
    end

    lz_run[NDIGITS] = 1'b1;
    for (int i = NDIGITS-1; i >= 0; i--)
      lz_run[i] = lz_run[i+1] && (snap_word_d[4*i +: 4] == 4'h0);

    // Decode from the _d snapshot so digit 0 shows the word loaded this edge
    nib    = '0;
    dark   = 1'b0;
    dp_sel = 1'b0;
    an_sel = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        nib       = snap_word_d[4*i +: 4];
        dark      = snap_blank_d[i] | (lz_suppress_i & (i != 0) & lz_run[i]);
        dp_sel    = snap_dp_d[i];
        an_sel[i] = 1'b1;
      end
    end

    an_d  = tick ? ~an_sel : an_q;
    seg_d = tick ? (dark ? 7'h7F : hex2seg(nib)) : seg_q;
    dp_d  = tick ? ~dp_sel : dp_q;
    fd_d  = boundary;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      presc_q      <= '0;
      idx_q        <= '0;
      snap_word_q  <= '0;
      snap_dp_q    <= '0;
      snap_blank_q <= '0;
      holding_q    <= 1'b0;
      an_q         <= '1;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      fd_q         <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      snap_word_q  <= snap_word_d;
      snap_dp_q    <= snap_dp_d;
      snap_blank_q <= snap_blank_d;
      holding_q    <= holding_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      fd_q         <= fd_d;
    end
  end

  assign an_o         = (ACTIVE_LOW != 0) ? an_q  : ~an_q;
  assign seg_o        = (ACTIVE_LOW != 0) ? seg_q : ~seg_q;
  assign dp_o         = (ACTIVE_LOW != 0) ? dp_q  : ~dp_q;
  assign frame_done_o = fd_q;
  assign holding_o    = holding_q;
endmodule

// File: tb/tb_seg7_scan_display.sv
module tb_seg7_scan_display;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] data_in, evt_data;
  logic [3:0]  dp_in, blank_in, an;
  logic        lz_suppress, evt_valid, evt_ready, dp, frame_done, holding;
  logic [6:0]  seg;

  int checks = 0;
  int errors = 0;

  seg7_scan_display #(.NDIGITS(4), .SCAN_DIV(4), .HOLD_FRAMES(2), .ACTIVE_LOW(1)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .data_in_i(data_in), .dp_in_i(dp_in),
    .blank_in_i(blank_in), .lz_suppress_i(lz_suppress), .evt_valid_i(evt_valid),
    .evt_data_i(evt_data), .evt_ready_o(evt_ready), .an_o(an), .seg_o(seg),
    .dp_o(dp), .frame_done_o(frame_done), .holding_o(holding)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]     data;
    logic [3:0]      dpi;
    logic [3:0]      blank;
    logic            lz;
    logic [3:0][6:0] seg;   // expected seg per digit {d3,d2,d1,d0}
    logic [3:0]      dpo;   // expected dp output per digit (low = lit)
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to the next negedge where frame_done is seen; bounded.
  task automatic wait_fd(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 64);
    if (!frame_done) begin
      checks++;
      errors++;
      $display("FAIL frame_done_timeout got none expected pulse within 64 cycles");
    end
  endtask

  task automatic chk_digit(input string name, input int d, input logic [6:0] es, input logic edp);
    logic [3:0] ea;
    ea = ~(4'b0001 << d);
    chk({name, "_an"}, 32'(an), 32'(ea));
    chk({name, "_seg"}, 32'(seg), 32'(es));
    chk({name, "_dp"}, 32'(dp), 32'(edp));
  endtask

  initial begin
    int n;
    vt[0] = '{16'h12AF, 4'h0, 4'h0, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF};
    vt[1] = '{16'h0030, 4'h0, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h30, 7'h40}, 4'hF};
    vt[2] = '{16'h0000, 4'h0, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF};
    vt[3] = '{16'h0000, 4'h0, 4'h0, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF};
    vt[4] = '{16'h89CD, 4'h5, 4'h2, 1'b0, {7'h00, 7'h10, 7'h7F, 7'h21}, 4'hA};
    vt[5] = '{16'h3456, 4'hA, 4'h0, 1'b1, {7'h30, 7'h19, 7'h12, 7'h02}, 4'h5};
    vt[6] = '{16'h0B07, 4'h0, 4'h8, 1'b1, {7'h7F, 7'h03, 7'h40, 7'h78}, 4'hF};
    vt[7] = '{16'h00E0, 4'h8, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h06, 7'h40}, 4'h7};

    reset_n = 1'b0; data_in = 16'h0; evt_data = 16'h0; dp_in = 4'h0;
    blank_in = 4'h0; lz_suppress = 1'b0; evt_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_ready", 32'(evt_ready), 32'h1);
    chk("rst_fd", 32'(frame_done), 32'h0);
    chk("rst_hold", 32'(holding), 32'h0);

    // First an change exactly 4 cycles after release; digit 1 of zero snapshot
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rel_an_c3", 32'(an), 32'hF);
    @(negedge clk);
    chk_digit("rel_c4", 1, 7'h40, 1'b1);

    // frame_done period
    wait_fd(n);
    wait_fd(n);
    chk("fd_period", 32'(n), 32'd16);

    // Table-driven frames: inputs applied before the boundary that loads them
    for (int v = 0; v < 8; v++) begin
      data_in = vt[v].data; dp_in = vt[v].dpi;
      blank_in = vt[v].blank; lz_suppress = vt[v].lz;
      wait_fd(n);
      for (int d = 0; d < 4; d++) begin
        if (d > 0) repeat (4) @(negedge clk);
        chk_digit($sformatf("vec%0d_d%0d", v, d), d, vt[v].seg[d], vt[v].dpo[d]);
      end
    end
    dp_in = 4'h0; blank_in = 4'h0; lz_suppress = 1'b0;

    // Mid-frame change: rest of the frame keeps the latched word
    data_in = 16'h1111;
    wait_fd(n);
    chk_digit("tear_d0", 0, 7'h79, 1'b1);
    repeat (4) @(negedge clk);
    data_in = 16'h2222;
    chk_digit("tear_d1", 1, 7'h79, 1'b1);
    repeat (4) @(negedge clk);
    chk_digit("tear_d2", 2, 7'h79, 1'b1);
    repeat (4) @(negedge clk);
    chk_digit("tear_d3", 3, 7'h79, 1'b1);
    wait_fd(n);
    chk_digit("tear_next_d0", 0, 7'h24, 1'b1);

    // Event hold: accepted just after a boundary
    data_in = 16'h1234;
    wait_fd(n);
    evt_valid = 1'b1; evt_data = 16'hBEEF;
    @(negedge clk);
    evt_valid = 1'b0;
    chk("evt_ready_drop", 32'(evt_ready), 32'h0);
    chk("evt_hold_before", 32'(holding), 32'h0);
    wait_fd(n);
    chk("evt_f1_hold", 32'(holding), 32'h1);
    chk_digit("evt_f1_d0", 0, 7'h0E, 1'b1);
    // Second offer during HOLD must not be taken
    evt_valid = 1'b1; evt_data = 16'h1111;
    repeat (3) @(negedge clk);
    chk("evt2_ready", 32'(evt_ready), 32'h0);
    evt_valid = 1'b0;
    wait_fd(n);
    chk("evt_f2_hold", 32'(holding), 32'h1);
    chk_digit("evt_f2_d0", 0, 7'h0E, 1'b1);
    repeat (12) @(negedge clk);
    chk_digit("evt_f2_d3", 3, 7'h03, 1'b1);
    wait_fd(n);
    chk("evt_end_hold", 32'(holding), 32'h0);
    chk("evt_end_ready", 32'(evt_ready), 32'h1);
    chk_digit("evt_end_d0", 0, 7'h19, 1'b1);
    wait_fd(n);
    chk("evt_after_hold", 32'(holding), 32'h0);
    chk_digit("evt_after_d0", 0, 7'h19, 1'b1);

    // Reset during HOLD discards the event
    evt_valid = 1'b1; evt_data = 16'hC0DE;
    @(negedge clk);
    evt_valid = 1'b0;
    chk("mid_ready_drop", 32'(evt_ready), 32'h0);
    wait_fd(n);
    chk("mid_hold", 32'(holding), 32'h1);
    chk_digit("mid_d0", 0, 7'h06, 1'b1);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_hold", 32'(holding), 32'h0);
    chk("mid_rst_ready", 32'(evt_ready), 32'h1);
    chk("mid_rst_an", 32'(an), 32'hF);
    chk("mid_rst_seg", 32'(seg), 32'h7F);
    chk("mid_rst_dp", 32'(dp), 32'h1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk_digit("post_rst_zero", 1, 7'h40, 1'b1);
    wait_fd(n);
    chk("post_rst_fd_lat", 32'(n), 32'd12);
    chk("post_rst_hold1", 32'(holding), 32'h0);
    chk_digit("post_rst_d0", 0, 7'h19, 1'b1);
    wait_fd(n);
    chk("post_rst_hold2", 32'(holding), 32'h0);
    chk("post_rst_ready", 32'(evt_ready), 32'h1);
    chk_digit("post_rst_d0b", 0, 7'h19, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
